r5fp_mac_sched: RTL

// Shares one fixed-latency R5FP fused multiply-add datapath (a*b+c) among N requesters.

---
 rtl/r5fp_mac_sched.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/r5fp_mac_sched.sv
// r5fp_mac_sched: shares one fixed-latency R5FP fused multiply-add datapath
// (a*b+c) among N_REQ requesters. A round-robin arbiter issues at most one
// op per cycle. Issue is credit-gated, so that every in-flight op has a
// reserved slot in its requester's response FIFO. Results come back in order
// per requester through valid/ready response ports.
// Optional feature macro: R5FP_SCHED_FLAG_ACC_EN adds per-requester sticky
// status accumulation (flag_acc) with a clear input (flag_clr).
module r5fp_mac_sched #(
    parameter  int EXP_W   = 8,
    parameter  int SIG_W   = 23,
    parameter  int N_REQ   = 2,
    parameter  int MAC_LAT = 1,
    parameter  int FIFO_D  = 2,
    localparam int W       = EXP_W + SIG_W + 1,
    localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    input  logic [N_REQ*W-1:0]   req_c,
    input  logic [N_REQ*3-1:0]   req_rnd,
    output logic [W-1:0]         mac_a,
    output logic [W-1:0]         mac_b,
    output logic [W-1:0]         mac_c,
    output logic [2:0]           mac_rnd,
    input  logic [W-1:0]         mac_z,
    input  logic [7:0]           mac_status,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [N_REQ*W-1:0]   rsp_z,
    output logic [N_REQ*8-1:0]   rsp_status
`ifdef R5FP_SCHED_FLAG_ACC_EN
    ,
    output logic [N_REQ*8-1:0]   flag_acc,
    input  logic [N_REQ-1:0]     flag_clr
`endif
);

    localparam int            CW    = $clog2(FIFO_D + 1);
    localparam int            AW    = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam logic [AW-1:0] AMASK = AW'(FIFO_D - 1);

    // Control state
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cred_q [N_REQ];
    logic [CW-1:0] cnt_q  [N_REQ];
    logic [AW-1:0] rd_q   [N_REQ];
    logic [AW-1:0] wr_q   [N_REQ];
    logic          tv_q   [MAC_LAT];
    logic [IW-1:0] tt_q   [MAC_LAT];

    // Response storage: {z, status} per slot
    logic [W+7:0]  mem_q  [N_REQ][FIFO_D];
    logic [W+7:0]  head_e [N_REQ];

    logic [N_REQ-1:0] elig, grant, pop, push;
    logic [IW-1:0]    win;
    logic             gnt_any;
    logic             found;
    int               j;

    // Eligibility: request pending and a response slot still unreserved
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = req_valid[i] && (cred_q[i] < CW'(FIFO_D));
        end
    end

    // Round-robin pick: first eligible index scanning upward from ptr
    always_comb begin
        grant = '0;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!found && elig[j]) begin
                found    = 1'b1;
                win      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

    assign gnt_any   = |grant;
    // Grants are suppressed while reset is held so no handshake is seen
    assign req_ready = reset ? grant : '0;

    // Next pointer: one past the winner, wrapping at N_REQ
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // Capture target decoded from the oldest tag stage
    always_comb begin
        push = '0;
        if (tv_q[MAC_LAT-1]) push[tt_q[MAC_LAT-1]] = 1'b1;
    end

    // FIFO heads drive the response ports; empty FIFOs present zero
    always_comb begin
        rsp_valid  = '0;
        rsp_z      = '0;
        rsp_status = '0;
        pop        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            head_e[i]            = mem_q[i][rd_q[i] & AMASK];
            rsp_valid[i]         = (cnt_q[i] != '0);
            pop[i]               = rsp_valid[i] && rsp_ready[i];
            rsp_z[i*W +: W]      = rsp_valid[i] ? head_e[i][W+7:8] : '0;
            rsp_status[i*8 +: 8] = rsp_valid[i] ? head_e[i][7:0]   : '0;
        end
    end

    // Arbiter pointer, credits and FIFO pointers/occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                cred_q[i] <= '0;
                cnt_q[i]  <= '0;
                rd_q[i]   <= '0;
                wr_q[i]   <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            for (int i = 0; i < N_REQ; i++) begin
                cred_q[i] <= cred_q[i] + CW'(grant[i]) - CW'(pop[i]);
                cnt_q[i]  <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
                if (pop[i])  rd_q[i] <= rd_q[i] + 1'b1;
                if (push[i]) wr_q[i] <= wr_q[i] + 1'b1;
            end
        end
    end

    // Tag pipe tracks which requester owns each op inside the datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < MAC_LAT; s++) begin
                tv_q[s] <= 1'b0;
                tt_q[s] <= '0;
            end
        end else begin
            tv_q[0] <= gnt_any;
            tt_q[0] <= win;
            for (int s = 1; s < MAC_LAT; s++) begin
                tv_q[s] <= tv_q[s-1];
                tt_q[s] <= tt_q[s-1];
            end
        end
    end

    // Launch registers: load winner operands, hold when nothing is granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_a   <= '0;
            mac_b   <= '0;
            mac_c   <= '0;
            mac_rnd <= '0;
        end else if (gnt_any) begin
            mac_a   <= req_a[int'(win)*W +: W];
            mac_b   <= req_b[int'(win)*W +: W];
            mac_c   <= req_c[int'(win)*W +: W];
            mac_rnd <= req_rnd[int'(win)*3 +: 3];
        end
    end

    // Response storage write; credits guarantee the target slot is free
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (push[i]) mem_q[i][wr_q[i] & AMASK] <= {mac_z, mac_status};
        end
    end

`ifdef R5FP_SCHED_FLAG_ACC_EN
    logic [7:0] flag_q [N_REQ];

    // Sticky OR of popped status; a pop in the clear cycle survives the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_REQ; i++) flag_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (pop[i]) begin
                    flag_q[i] <= (flag_clr[i] ? 8'h00 : flag_q[i]) | head_e[i][7:0];
                end else if (flag_clr[i]) begin
                    flag_q[i] <= 8'h00;
                end
            end
        end
    end

    // Flatten accumulated flags onto the output bus
    always_comb begin
        flag_acc = '0;
        for (int i = 0; i < N_REQ; i++) flag_acc[i*8 +: 8] = flag_q[i];
    end
`endif

endmodule
